// File: rtl/op_dispatch_sched.sv
// Operation dispatcher: pops packets from the input FIFO and hands each one to an
// idle, ready compute engine chosen round-robin; tracks engine busy until done.
module op_dispatch_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 3,
  parameter int RES_WIDTH  = 4,
  parameter int NUM_ENG    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_pkt_available,
  input  logic [DATA_WIDTH-1:0] in_fifo_data_i,
  input  logic [NUM_MODES-1:0]  in_fifo_mode_i,
  input  logic [RES_WIDTH-1:0]  in_fifo_res_i,
  output logic                  fifo_pop,
  output logic [NUM_ENG-1:0]    eng_valid,
  output logic [DATA_WIDTH-1:0] eng_data,
  output logic [NUM_MODES-1:0]  eng_mode,
  output logic [RES_WIDTH-1:0]  eng_res,
  input  logic [NUM_ENG-1:0]    eng_ready,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic [NUM_ENG-1:0]    eng_busy,
  output logic                  sched_idle,
  output logic [15:0]           disp_cnt
);

  localparam int PTR_W = $clog2(NUM_ENG);
  localparam logic [NUM_ENG-1:0] ENG_ONE = NUM_ENG'(1);
  localparam logic [PTR_W:0] ENG_COUNT = (PTR_W + 1)'(NUM_ENG);
  localparam logic [PTR_W-1:0] ENG_LAST = PTR_W'(NUM_ENG - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ARB,
    SEND
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [NUM_MODES-1:0]  hold_mode;
  logic [RES_WIDTH-1:0]  hold_res;

  logic [NUM_ENG-1:0]    elig;
  logic                  arb_found;
  logic [PTR_W-1:0]      arb_idx;
  logic [PTR_W:0]        cand;
  logic                  handshake;
  logic [NUM_ENG-1:0]    busy_set;
  logic [NUM_ENG-1:0]    busy_next;
  logic [PTR_W-1:0]      rr_next;

  // Busy is read as registered, so a done arriving this cycle does not make
  // its engine eligible until the following cycle.
  always_comb begin
    elig      = ~eng_busy & eng_ready;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (cand >= ENG_COUNT) begin
        cand = cand - ENG_COUNT;
      end
      if (!arb_found && elig[cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    handshake = (state == SEND) && eng_ready[sel_idx];
    busy_set  = handshake ? (ENG_ONE << sel_idx) : '0;
    busy_next = (eng_busy & ~eng_done) | busy_set;
    rr_next   = (sel_idx == ENG_LAST) ? '0 : sel_idx + 1'b1;
  end

  // The pop strobe is gated by reset so nothing leaves the FIFO while the
  // scheduler is being cleared.
  assign fifo_pop   = (state == IDLE) && op_pkt_available && !rst;
  assign sched_idle = (state == IDLE) && (eng_busy == '0) && !op_pkt_available;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel_idx   <= '0;
      hold_data <= '0;
      hold_mode <= '0;
      hold_res  <= '0;
      eng_valid <= '0;
      eng_data  <= '0;
      eng_mode  <= '0;
      eng_res   <= '0;
      eng_busy  <= '0;
      disp_cnt  <= '0;
    end else begin
      eng_busy <= busy_next;
      case (state)
        IDLE: begin
          if (op_pkt_available) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          hold_data <= in_fifo_data_i;
          hold_mode <= in_fifo_mode_i;
          hold_res  <= in_fifo_res_i;
          state     <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            eng_valid <= ENG_ONE << arb_idx;
            sel_idx   <= arb_idx;
            eng_data  <= hold_data;
            eng_mode  <= hold_mode;
            eng_res   <= hold_res;
            state     <= SEND;
          end
        end
        SEND: begin
          // The chosen engine is kept even if its ready drops meanwhile.
          if (handshake) begin
            rr_ptr    <= rr_next;
            disp_cnt  <= disp_cnt + 16'd1;
            eng_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_dispatch_sched.sv
// Self-checking bench for op_dispatch_sched: a FIFO model feeds packets, and a
// scoreboard of expected engine/payload pairs is checked at every dispatch handshake.
module tb_op_dispatch_sched;

  localparam int DW = 32;
  localparam int MW = 3;
  localparam int RW = 4;
  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_pkt_available;
  logic [DW-1:0] in_fifo_data_i;
  logic [MW-1:0] in_fifo_mode_i;
  logic [RW-1:0] in_fifo_res_i;
  logic          fifo_pop;
  logic [NE-1:0] eng_valid;
  logic [DW-1:0] eng_data;
  logic [MW-1:0] eng_mode;
  logic [RW-1:0] eng_res;
  logic [NE-1:0] eng_ready;
  logic [NE-1:0] eng_done;
  logic [NE-1:0] eng_busy;
  logic          sched_idle;
  logic [15:0]   disp_cnt;

  always #5 clk = ~clk;

  op_dispatch_sched #(
    .DATA_WIDTH(DW),
    .NUM_MODES (MW),
    .RES_WIDTH (RW),
    .NUM_ENG   (NE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .op_pkt_available(op_pkt_available),
    .in_fifo_data_i  (in_fifo_data_i),
    .in_fifo_mode_i  (in_fifo_mode_i),
    .in_fifo_res_i   (in_fifo_res_i),
    .fifo_pop        (fifo_pop),
    .eng_valid       (eng_valid),
    .eng_data        (eng_data),
    .eng_mode        (eng_mode),
    .eng_res         (eng_res),
    .eng_ready       (eng_ready),
    .eng_done        (eng_done),
    .eng_busy        (eng_busy),
    .sched_idle      (sched_idle),
    .disp_cnt        (disp_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] mode;
    logic [RW-1:0] res;
  } pkt_t;

  typedef struct packed {
    logic [NE-1:0] eng;
    pkt_t          p;
  } exp_t;

  pkt_t          fifo_q[$];
  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            pop_cnt = 0;
  int            last_pop_cyc = -1;
  int            first_valid_cyc = -1;
  int            start_pops;
  bit            auto_done = 1'b0;
  logic [NE-1:0] prev_valid = '0;
  pkt_t          pa, pb, pc, px, py;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic [RW-1:0] r);
    pkt_t p;
    p.data = d;
    p.mode = m;
    p.res  = r;
    return p;
  endfunction

  // Samples the DUT mid-cycle, then advances one clock and updates the FIFO model.
  task automatic tick();
    logic          pop_now;
    logic [NE-1:0] hs;
    exp_t          e;
    @(negedge clk);
    hs = eng_valid & eng_ready;
    if (eng_valid != '0 && prev_valid == '0) first_valid_cyc = cyc;
    prev_valid = eng_valid;
    if (hs != '0) begin
      checkOutput("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("disp_eng", 64'(eng_valid), 64'(e.eng));
        checkOutput("disp_data", 64'(eng_data), 64'(e.p.data));
        checkOutput("disp_mode", 64'(eng_mode), 64'(e.p.mode));
        checkOutput("disp_res", 64'(eng_res), 64'(e.p.res));
      end
    end
    pop_now = fifo_pop;
    if (pop_now) begin
      pop_cnt++;
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    eng_done = auto_done ? hs : '0;
    if (pop_now && fifo_q.size() != 0) begin
      in_fifo_data_i = fifo_q[0].data;
      in_fifo_mode_i = fifo_q[0].mode;
      in_fifo_res_i  = fifo_q[0].res;
      void'(fifo_q.pop_front());
    end
    op_pkt_available = (fifo_q.size() != 0);
  endtask

  task automatic applyStimulus(input pkt_t p, input logic [NE-1:0] exp_eng, input bit expect_disp);
    exp_t e;
    fifo_q.push_back(p);
    if (expect_disp) begin
      e.eng = exp_eng;
      e.p   = p;
      sb_q.push_back(e);
    end
    op_pkt_available = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulseDone(input logic [NE-1:0] m);
    eng_done = m;
    tick();
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic waitPop(input int budget);
    int n = 0;
    int s = pop_cnt;
    while (pop_cnt == s && n < budget) begin
      tick();
      n++;
    end
    checkOutput("pop_timeout", 64'(pop_cnt != s), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    op_pkt_available = 1'b0;
    in_fifo_data_i   = '0;
    in_fifo_mode_i   = '0;
    in_fifo_res_i    = '0;
    eng_ready        = '1;
    eng_done         = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_valid", 64'(eng_valid), 64'd0);
    checkOutput("rst_busy", 64'(eng_busy), 64'd0);
    checkOutput("rst_cnt", 64'(disp_cnt), 64'd0);
    checkOutput("rst_pop", 64'(fifo_pop), 64'd0);
    checkOutput("rst_idle", 64'(sched_idle), 64'd1);
    checkOutput("rst_data", 64'(eng_data), 64'd0);

    // Single packet to engine 0 with three-cycle pop-to-valid latency
    applyStimulus(mk(32'hDEADBEEF, 3'b010, 4'h5), 4'b0001, 1'b1);
    waitDrain(20);
    checkOutput("t1_latency", 64'(first_valid_cyc - last_pop_cyc), 64'd3);
    checkOutput("t1_busy", 64'(eng_busy), 64'b0001);
    checkOutput("t1_cnt", 64'(disp_cnt), 64'd1);
    checkOutput("t1_idle", 64'(sched_idle), 64'd0);

    // Five packets, no done: fifth waits until engine 2 completes
    doReset();
    start_pops = pop_cnt;
    applyStimulus(mk(32'h11111111, 3'd1, 4'h1), 4'b0001, 1'b1);
    applyStimulus(mk(32'h22222222, 3'd2, 4'h2), 4'b0010, 1'b1);
    applyStimulus(mk(32'h33333333, 3'd3, 4'h3), 4'b0100, 1'b1);
    applyStimulus(mk(32'h44444444, 3'd4, 4'h4), 4'b1000, 1'b1);
    applyStimulus(mk(32'h55555555, 3'd5, 4'h6), 4'b0100, 1'b1);
    for (int n = 0; n < 60 && sb_q.size() > 1; n++) tick();
    for (int n = 0; n < 12; n++) tick();
    checkOutput("t2_stall_valid", 64'(eng_valid), 64'd0);
    checkOutput("t2_stall_busy", 64'(eng_busy), 64'hF);
    checkOutput("t2_pops", 64'(pop_cnt - start_pops), 64'd5);
    checkOutput("t2_cnt4", 64'(disp_cnt), 64'd4);
    pulseDone(4'b0100);
    waitDrain(20);
    checkOutput("t2_busy_end", 64'(eng_busy), 64'hF);
    checkOutput("t2_cnt5", 64'(disp_cnt), 64'd5);

    // Ready drop on the chosen engine while in SEND
    doReset();
    pa = mk(32'hA0A0A0A0, 3'd0, 4'hA);
    pb = mk(32'hB1B2B3B4, 3'd6, 4'hB);
    pc = mk(32'hC0FFEE00, 3'd7, 4'hC);
    applyStimulus(pa, 4'b0001, 1'b1);
    waitDrain(20);
    start_pops = pop_cnt;
    applyStimulus(pb, 4'b0010, 1'b1);
    applyStimulus(pc, 4'b0100, 1'b1);
    waitPop(10);
    tick();
    tick();
    eng_ready = 4'b1101;
    checkOutput("t3_send_valid", 64'(eng_valid), 64'b0010);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("t3_hold_valid", 64'(eng_valid), 64'b0010);
      checkOutput("t3_hold_data", 64'(eng_data), 64'(pb.data));
      checkOutput("t3_no_pop", 64'(pop_cnt - start_pops), 64'd1);
    end
    eng_ready = '1;
    tick();
    checkOutput("t3_busy", 64'(eng_busy), 64'b0011);
    tick();
    checkOutput("t3_next_pop", 64'(pop_cnt - start_pops), 64'd2);
    waitDrain(20);

    // Pointer wrap: rr_ptr=3 with engine 3 busy sends to 0, then to 1
    doReset();
    applyStimulus(mk(32'h00000010, 3'd1, 4'h0), 4'b0001, 1'b1);
    applyStimulus(mk(32'h00000011, 3'd1, 4'h1), 4'b0010, 1'b1);
    applyStimulus(mk(32'h00000012, 3'd1, 4'h2), 4'b0100, 1'b1);
    applyStimulus(mk(32'h00000013, 3'd1, 4'h3), 4'b1000, 1'b1);
    waitDrain(60);
    pulseDone(4'b0111);
    applyStimulus(mk(32'h00000020, 3'd2, 4'h4), 4'b0001, 1'b1);
    applyStimulus(mk(32'h00000021, 3'd2, 4'h5), 4'b0010, 1'b1);
    applyStimulus(mk(32'h00000022, 3'd2, 4'h6), 4'b0100, 1'b1);
    waitDrain(60);
    pulseDone(4'b0111);
    checkOutput("t4_busy_pre", 64'(eng_busy), 64'b1000);
    applyStimulus(mk(32'h00000030, 3'd3, 4'h7), 4'b0001, 1'b1);
    waitDrain(20);
    checkOutput("t4_busy_post", 64'(eng_busy), 64'b1001);
    applyStimulus(mk(32'h00000031, 3'd3, 4'h8), 4'b0010, 1'b1);
    waitDrain(20);

    // Reset during SEND drops the held packet; the next FIFO entry follows
    doReset();
    px = mk(32'hBAD0BAD0, 3'd5, 4'hE);
    py = mk(32'h600D600D, 3'd3, 4'h9);
    start_pops = pop_cnt;
    applyStimulus(px, 4'b0001, 1'b0);
    applyStimulus(py, 4'b0001, 1'b1);
    waitPop(10);
    tick();
    tick();
    eng_ready = '0;
    checkOutput("t5_send_valid", 64'(eng_valid), 64'b0001);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_valid", 64'(eng_valid), 64'd0);
    checkOutput("t5_rst_busy", 64'(eng_busy), 64'd0);
    checkOutput("t5_rst_cnt", 64'(disp_cnt), 64'd0);
    rst = 1'b0;
    eng_ready = '1;
    waitDrain(20);
    checkOutput("t5_cnt", 64'(disp_cnt), 64'd1);
    checkOutput("t5_pops", 64'(pop_cnt - start_pops), 64'd2);

    // Stream with immediate done: rotation through all engines, ends idle
    doReset();
    auto_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(mk(DW'($urandom), MW'($urandom_range(0, 7)), RW'($urandom_range(0, 15))),
                    NE'(1) << (i % NE), 1'b1);
    end
    waitDrain(40 * 6 + 20);
    tick();
    tick();
    tick();
    auto_done = 1'b0;
    checkOutput("t6_cnt", 64'(disp_cnt), 64'd40);
    checkOutput("t6_busy", 64'(eng_busy), 64'd0);
    checkOutput("t6_idle", 64'(sched_idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
